aic_inv_mixcol: RTL and testbench

Sequencer for the AES InvMixColumns step in the AES ISE datapath. Takes a state column, or the full 128-bit state, and drives one `aic_mul_acc` instance four times per column, with `sel` = 0..3. It packs the four returned bytes into the output column and signals completion with a one-cycle `done` pulse. It sits between the ISE register-file operand/result interface and `aic_mul_acc`.

---
 rtl/aic_pkg.sv | 25 ++
 rtl/aic_mul_acc.sv | 84 ++++++++
 rtl/aic_inv_mixcol.sv | 116 +++++++++++
 tb/tb_aic_inv_mixcol.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/aic_pkg.sv
// Shared types and constants for the AES InvMixColumns sequencer.
// Width follows AIC_STATE_128_EN: 128-bit state (4 columns) when defined,
// a single 32-bit column otherwise.
package aic_pkg;

  localparam int BYTE_W = 8;
  localparam int COL_W  = 32;

`ifdef AIC_STATE_128_EN
  localparam int NCOL = 4;
`else
  localparam int NCOL = 1;
`endif

  localparam int W  = NCOL * COL_W;
  localparam int CW = (NCOL > 1) ? $clog2(NCOL) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/aic_mul_acc.sv
// GF(2^8) multiply-accumulate: one InvMixColumns output byte for row sel.
// Latency: start high in cycle c gives done (one-cycle pulse) in cycle c+5.
// No backpressure; s0..s3 and sel must stay stable from start until done.
// Ports: clk/rst (sync, active-high), start, s0..s3 column bytes rows 0..3,
//        sel output row, done completion pulse, result output byte.
module aic_mul_acc
  import aic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] s0,
  input  logic [BYTE_W-1:0] s1,
  input  logic [BYTE_W-1:0] s2,
  input  logic [BYTE_W-1:0] s3,
  input  logic [1:0]        sel,
  output logic              done,
  output logic [BYTE_W-1:0] result
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Coefficient index k selects 0e, 0b, 0d, 09 (the circulant's first row).
  function automatic logic [7:0] gmul_coef(input logic [7:0] b, input logic [1:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    case (k)
      2'd0:    return x8 ^ x4 ^ x2;
      2'd1:    return x8 ^ x2 ^ b;
      2'd2:    return x8 ^ x4 ^ b;
      default: return x8 ^ b;
    endcase
  endfunction

  logic        run;
  logic [1:0]  j;
  logic [7:0]  acc;
  logic [7:0]  op;
  logic [1:0]  k;
  logic [7:0]  term;

  always_comb begin
    op = s0;
    case (j)
      2'd0:    op = s0;
      2'd1:    op = s1;
      2'd2:    op = s2;
      default: op = s3;
    endcase
    // Row sel uses the coefficient row rotated right by sel; 2-bit wrap is the mod 4.
    k    = j - sel;
    term = gmul_coef(op, k);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run  <= 1'b0;
      j    <= 2'd0;
      acc  <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        j   <= 2'd0;
        acc <= '0;
      end else if (run) begin
        acc <= acc ^ term;
        j   <= j + 2'd1;
        if (j == 2'd3) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign result = acc;

endmodule

// File: rtl/aic_inv_mixcol.sv
// InvMixColumns sequencer: runs aic_mul_acc once per output byte (sel = row).
// Latency: done at cycle 4*NCOL*(Lma+1)+1 after start is accepted.
// No backpressure; start is sampled only in IDLE, ignored while busy.
// Macro AIC_STATE_128_EN selects a 128-bit state (4 columns); default is 32 bits.
// Ports: clk, rst (sync, active-high), start, din (W), dout (W, valid from done),
//        done (one-cycle pulse), busy (high outside IDLE).
module aic_inv_mixcol
  import aic_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         done,
  output logic         busy
);

  state_t      state, nxt;
  logic [W-1:0] col_reg;
  logic [W-1:0] res_reg;
  logic [CW-1:0] ccnt;
  logic [1:0]   rcnt;
  logic [COL_W-1:0] cur_col;
  logic         ma_start;
  logic         ma_done;
  logic [BYTE_W-1:0] ma_result;
  logic         last_row;
  logic         last_col;

`ifdef AIC_STATE_128_EN
  assign cur_col = col_reg[W-1-COL_W*int'(ccnt) -: COL_W];
`else
  assign cur_col = col_reg;
`endif

  assign last_row = (rcnt == 2'd3);
  // Single-column build keeps ccnt at 0, so this is always true there.
  assign last_col = (ccnt == CW'(NCOL-1));

  aic_mul_acc u_mul_acc (
    .clk    (clk),
    .rst    (rst),
    .start  (ma_start),
    .s0     (cur_col[31:24]),
    .s1     (cur_col[23:16]),
    .s2     (cur_col[15:8]),
    .s3     (cur_col[7:0]),
    .sel    (rcnt),
    .done   (ma_done),
    .result (ma_result)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = LAUNCH;
      LAUNCH:  nxt = WAIT;
      WAIT:    if (ma_done) nxt = (last_row && last_col) ? FINISH : LAUNCH;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    ma_start = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE:    busy     = 1'b0;
      LAUNCH:  ma_start = 1'b1;
      FINISH:  done     = 1'b1;
      default: ;
    endcase
  end

  // Operands and sel come straight from these registers, so they hold
  // steady for the whole aic_mul_acc run.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg <= '0;
      res_reg <= '0;
      ccnt    <= '0;
      rcnt    <= 2'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          col_reg <= din;
          ccnt    <= '0;
          rcnt    <= 2'd0;
        end
        WAIT: if (ma_done) begin
`ifdef AIC_STATE_128_EN
          res_reg[W-1-COL_W*int'(ccnt)-BYTE_W*int'(rcnt) -: BYTE_W] <= ma_result;
`else
          res_reg[W-1-BYTE_W*int'(rcnt) -: BYTE_W] <= ma_result;
`endif
          if (!(last_row && last_col)) begin
            rcnt <= rcnt + 2'd1;
`ifdef AIC_STATE_128_EN
            if (last_row) ccnt <= ccnt + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = res_reg;

endmodule

// File: tb/tb_aic_inv_mixcol.sv
// Directed bench for aic_inv_mixcol; expected results are FIPS-197 column
// pairs, latency uses the 5-cycle aic_mul_acc run (Lma = 5).
module tb_aic_inv_mixcol;
  import aic_pkg::*;

  localparam int LMA     = 5;
  localparam int RUN_LAT = 4*NCOL*(LMA+1) + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         done;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int ms_cnt = 0;

  aic_inv_mixcol dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .din   (din),
    .dout  (dout),
    .done  (done),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (dut.ma_start) ms_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start for one cycle, then waits (bounded) for done.
  // lat = cycles from the accepting edge's cycle (0) to the done cycle.
  task automatic run(input logic [W-1:0] d, output int lat);
    @(negedge clk);
    start = 1'b1;
    din   = d;
    @(negedge clk);
    start = 1'b0;
    check("busy_rise", busy, 1);
    lat = 1;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat;
    int c0;
    int m0;
    rst   = 1'b1;
    start = 1'b0;
    din   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_dout", dout, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);

`ifdef AIC_STATE_128_EN
    m0 = ms_cnt;
    run(128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6, lat);
    check("lat128", lat, RUN_LAT);
    check("dout128", dout, 128'hdb135345_f20a225c_01010101_d4d4d4d5);
    @(negedge clk);
    check("ma_start16", ms_cnt - m0, 16);
    check("busy_fall128", busy, 0);
`else
    // Basic column
    m0 = ms_cnt;
    run(32'h8e4da1bc, lat);
    check("lat1", lat, RUN_LAT);
    check("dout1", dout, 32'hdb135345);
    check("ma_start4", ms_cnt - m0, 4);
    @(negedge clk);
    check("busy_fall1", busy, 0);
    check("done_fall1", done, 0);

    // Back-to-back identity columns
    c0 = done_cnt;
    run(32'h01010101, lat);
    check("lat_id1", lat, RUN_LAT);
    check("dout_id1", dout, 32'h01010101);
    run(32'hc6c6c6c6, lat);
    check("lat_id2", lat, RUN_LAT);
    check("dout_id2", dout, 32'hc6c6c6c6);
    @(negedge clk);
    check("b2b_done_cnt", done_cnt - c0, 2);

    // start during WAIT with a different din must be ignored
    c0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    din   = 32'hd5d5d7d6;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 400) begin
      if (lat == 3) begin
        start = 1'b1;
        din   = 32'h8e4da1bc;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("lat_ign", lat, RUN_LAT);
    check("dout_ign", dout, 32'hd4d4d4d5);
    repeat (40) @(negedge clk);
    check("ign_done_cnt", done_cnt - c0, 1);
`endif

    // Reset during the third aic_mul_acc run (WAIT spans cycles 14..18)
    c0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    din   = {NCOL{32'h8e4da1bc}};
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (lat < 15) begin
      @(negedge clk);
      lat++;
    end
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dout", dout, 0);
    check("mid_rst_done", done, 0);
    repeat (30) @(negedge clk);
    check("mid_rst_no_done", done_cnt - c0, 0);

    run({NCOL{32'h4d7ebdf8}}, lat);
    check("lat_post_rst", lat, RUN_LAT);
    check("dout_post_rst", dout, {NCOL{32'h2d26314c}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
